// File: rtl/alu_negate_arbiter.sv
// Shared negate/subtract engine: round-robin arbitration between two requesters,
// sequenced NEG -> ADD -> DONE, with a registered, ID-tagged valid/ready response.
module alu_negate_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carry,
    output logic             resp_ovf,
    output logic [7:0]       done_count
);

    typedef enum logic [1:0] {S_IDLE, S_NEG, S_ADD, S_DONE} state_t;

    localparam logic [1:0] OP_NEG  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ABS  = 2'b10;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nxt;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic             resp_hs;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, t_q;
    logic             id_q;

    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] add_result;
    logic             add_carry;
    logic             add_ovf;

    // Round-robin only matters on a tie; a lone requester always wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else if (req1_valid)          grant = 1'b1;
    end

    // rst_n gates the readies so no handshake is advertised while held in reset.
    assign accept     = rst_n && (state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept &&  grant;
    assign resp_hs    = (state == S_DONE) && resp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)  state_nxt = S_NEG;
            S_NEG:               state_nxt = S_ADD;
            S_ADD:               state_nxt = S_DONE;
            S_DONE: if (resp_hs) state_nxt = S_IDLE;
            default:             state_nxt = S_IDLE;
        endcase
    end

    // Subtract uses a + ~b + 1 directly so the carry is correct for b == 0.
    assign sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        add_result = a_q;
        add_carry  = 1'b0;
        add_ovf    = 1'b0;
        case (op_q)
            OP_SUB: begin
                add_result = sub_sum[WIDTH-1:0];
                add_carry  = sub_sum[WIDTH];
                add_ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (sub_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NEG: begin
                add_result = t_q;
                add_ovf    = (a_q == MIN_NEG);
            end
            OP_ABS: begin
                add_result = a_q[WIDTH-1] ? t_q : a_q;
                add_ovf    = (a_q == MIN_NEG);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            t_q         <= '0;
            id_q        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_carry  <= 1'b0;
            resp_ovf    <= 1'b0;
            done_count  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (accept) begin
                    op_q <= grant ? req1_op : req0_op;
                    a_q  <= grant ? req1_a  : req0_a;
                    b_q  <= grant ? req1_b  : req0_b;
                    id_q <= grant;
                end
                S_NEG: t_q <= ~((op_q == OP_SUB) ? b_q : a_q) + 1'b1;
                S_ADD: begin
                    resp_valid  <= 1'b1;
                    resp_id     <= id_q;
                    resp_result <= add_result;
                    resp_carry  <= add_carry;
                    resp_ovf    <= add_ovf;
                end
                S_DONE: if (resp_hs) begin
                    resp_valid <= 1'b0;
                    done_count <= done_count + 8'd1;
                    last_grant <= resp_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_negate_arbiter.sv
// Directed bench for alu_negate_arbiter: vector table for single requests plus
// round-robin, backpressure and mid-operation reset sequences.
module tb_alu_negate_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       resp_valid, resp_ready, resp_id, resp_carry, resp_ovf;
    logic [7:0] resp_result, done_count;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    localparam logic [1:0] NEG = 2'b00, SUB = 2'b01, ABS = 2'b10, PASS = 2'b11;

    typedef struct {
        logic       port;
        logic [1:0] op;
        logic [7:0] a, b;
        logic [7:0] result;
        logic       carry, ovf;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_negate_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_carry(resp_carry), .resp_ovf(resp_ovf),
        .done_count(done_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_resp(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check({tag, " resp_valid seen"}, resp_valid, 1);
    endtask

    task automatic resp_handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_done++;
        check({tag, " done_count"}, done_count, exp_done[7:0]);
        check({tag, " resp_valid cleared"}, resp_valid, 0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        int lat;
        @(negedge clk);
        if (v.port) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        #1;
        n = 0;
        while (!(v.port ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, " ready"}, v.port ? req1_ready : req0_ready, 1);
        check({tag, " other ready"}, v.port ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        // Change everything after the handshake; the captured copy must be used.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~req0_a; req0_b = ~req0_b; req0_op = ~req0_op;
        req1_a = ~req1_a; req1_b = ~req1_b; req1_op = ~req1_op;
        wait_resp(tag, lat);
        check({tag, " latency"}, lat, 3);
        check({tag, " id"}, resp_id, v.port);
        check({tag, " result"}, resp_result, v.result);
        check({tag, " carry"}, resp_carry, v.carry);
        check({tag, " ovf"}, resp_ovf, v.ovf);
        resp_handshake(tag);
    endtask

    initial begin
        int lat;
        int n;
        logic g;

        //         port op    a      b      result carry ovf
        vecs[0]  = '{1'b0, SUB,  8'h05, 8'h03, 8'h02, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, NEG,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, NEG,  8'h80, 8'h00, 8'h80, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, ABS,  8'hFB, 8'h00, 8'h05, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, ABS,  8'h80, 8'h00, 8'h80, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, PASS, 8'h9C, 8'h00, 8'h9C, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, SUB,  8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, SUB,  8'h10, 8'h00, 8'h10, 1'b1, 1'b0};
        vecs[10] = '{1'b1, ABS,  8'h05, 8'h00, 8'h05, 1'b0, 1'b0};

        rst_n = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = SUB; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b1; req1_op = SUB; req1_a = 8'h00; req1_b = 8'h00;
        repeat (2) @(negedge clk);
        check("reset req0_ready", req0_ready, 0);
        check("reset req1_ready", req1_ready, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_id", resp_id, 0);
        check("reset resp_result", resp_result, 0);
        check("reset resp_carry", resp_carry, 0);
        check("reset resp_ovf", resp_ovf, 0);
        check("reset done_count", done_count, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Both held valid: last grant was requester 1, so grants go 0,1,0,1.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = SUB;  req0_a = 8'h20; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = PASS; req1_a = 8'h44; req1_b = 8'h00;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk); #1;
                n++;
            end
            check($sformatf("rr%0d onehot", k), {30'd0, req1_ready, req0_ready}, k % 2 ? 2 : 1);
            g = req1_ready;
            @(posedge clk); #1;
            wait_resp($sformatf("rr%0d", k), lat);
            check($sformatf("rr%0d id", k), resp_id, k % 2);
            check($sformatf("rr%0d result", k), resp_result, g ? 8'h44 : 8'h1F);
            check($sformatf("rr%0d carry", k), resp_carry, g ? 0 : 1);
            resp_handshake($sformatf("rr%0d", k));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure: response held for 10 cycles while requester 1 waits.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = SUB;  req0_a = 8'h33; req0_b = 8'h11;
        req1_valid = 1'b1; req1_op = PASS; req1_a = 8'h55; req1_b = 8'h00;
        #1;
        check("bp req0 granted", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_resp("bp", lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d", c),
                  {20'd0, resp_valid, resp_id, resp_carry, resp_ovf, resp_result},
                  {20'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22});
            check($sformatf("bp readies%0d", c), {req1_ready, req0_ready}, 0);
        end
        resp_handshake("bp");
        check("bp grant next cycle", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp("bp2", lat);
        check("bp2 id", resp_id, 1);
        check("bp2 result", resp_result, 8'h55);
        resp_handshake("bp2");

        // Reset while the transaction sits in ADD: it must vanish.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = SUB; req0_a = 8'h40; req0_b = 8'h01;
        #1;
        check("rst req0 ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("rst resp_valid", resp_valid, 0);
        check("rst done_count", done_count, 0);
        check("rst readies", {req1_ready, req0_ready}, 0);
        repeat (2) @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b1;
        exp_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst no resp%0d", c), resp_valid, 0);
        end
        run_txn('{1'b0, SUB, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0}, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
